alu_mdu_controller: RTL and testbench
=====================================

Name: alu_mdu_controller

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes `alu_op`/`func` into the 3-bit ALU operation using the same codes. Adds an iterative multiply/divide unit (MDU) with HI/LO registers, a stall handshake and MFHI/MFLO result selection.
- Sits between the main controller/ID-EX stage and the datapath ALU. The datapath muxes `result_sel` between the ALU output and `hi`/`lo`.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits; power of two, minimum 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  instruction present this cycle.
- alu_op  in  2  00 MTYPE, 01 BTYPE, 10 RTYPE, 11 JTYPE.
- func  in  6  R-type function field.
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- alu_operation  out  3  ALU operation code (combinational).
- result_sel  out  2  00 ALU, 01 HI, 10 LO (combinational).
- stall  out  1  hold the pipeline this cycle (combinational).
- busy  out  1  MDU iterating (registered).
- done  out  1  one-cycle pulse when HI/LO are written (registered).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, internal shift registers=0. `rst_n` low mid-operation aborts; HI/LO return to 0.
- ALU decode (combinational, independent of `valid`):
  - MTYPE→ALU_ADD; BTYPE→ALU_SUB; JTYPE→ALU_OFF.
  - RTYPE: func 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; all other funcs→ALU_OFF.
- MDU funcs (RTYPE only): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO.
- `result_sel`: 01 for MFHI, 10 for MFLO, else 00.
- `stall` = `valid` & MDU func & (state≠IDLE).
  - MFHI/MFLO and new MULT/DIV wait for completion.
  - Non-MDU instructions never stall.
- FSM IDLE/RUN/FIN:
  - IDLE: `valid` & MULT*/DIV* & not stalled → latch operands. Signed ops store magnitudes plus sign flags (quotient sign = sa^sb, remainder sign = sa). Counter=WIDTH. →RUN.
  - RUN: one radix-2 step per cycle; counter decrements. Counter reaches 1 → FIN.
    - Multiply: shift-add, 2*WIDTH product.
    - Divide: restoring shift-subtract.
  - FIN: apply sign fixup (two's-complement negate), write HI/LO, `done`=1 for this cycle, →IDLE.
- `busy` = (state≠IDLE). Issue at edge k → busy in cycles k+1..k+WIDTH+1; `done` in cycle k+WIDTH+1; HI/LO valid from k+WIDTH+2. A stalled MFHI sees the new value on its first unstalled cycle.
- Result mapping:
  - MULT/MULTU: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV/DIVU: LO=quotient, HI=remainder.
- Divide by zero: no trap. LO=all ones, HI=dividend (as given, sign preserved). Still takes the full latency.
- Signed overflow DIV (most-negative / -1): LO=most-negative, HI=0. Falls out of the magnitude datapath; no special case.
- MULT with a most-negative operand: magnitude is held as unsigned WIDTH bits, so the result is exact.
- Simultaneous events: a request in the FIN cycle is stalled and accepted in the following IDLE cycle (no back-to-back issue in FIN).
- HI/LO change only in FIN or on reset.

Decomposition:
- Shared constants header: ALU_ADD/SUB/AND/OR/SLT/OFF codes, alu_op type codes, R-type func codes (including the six MDU funcs), result_sel codes.
- One sub-module: `mdu_iter` (WIDTH, handles the FSM, counter, shift datapath and sign fixup).
- Top level: decode, stall, `result_sel`.

Test Plan:
- Decode sweep: alu_op=10, func=101010 → ALU_SLT, `result_sel`=00, `stall`=0. alu_op=00 → ALU_ADD; alu_op=11 → ALU_OFF; func=111111 → ALU_OFF.
- MULT -3×7 (WIDTH=32): `busy` for 33 cycles, `done` pulse once. HI=FFFFFFFF, LO=FFFFFFEB. MULTU 0xFFFFFFFF×2 → HI=1, LO=FFFFFFFE.
- DIV -7/2 → LO=FFFFFFFD (-3), HI=FFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2.
- Divide by zero: DIVU 5/0 → LO=FFFFFFFF, HI=5, full latency, no hang.
- Hazard: MULT then MFLO next cycle → `stall`=1 until cycle after FIN. MFLO `result_sel`=10 with the new LO. An ADD issued while busy → `stall`=0.
- Reset mid-RUN (`rst_n` low 1 cycle at iteration 10) → `busy`=0, HI=LO=0 immediately. A fresh MULT 6×7 then gives LO=42.

Source files
------------

// File: rtl/alu_mdu_controller_pkg.sv
// alu_mdu_controller_pkg
//   Shared constants for the ALU control decoder and the iterative
//   multiply/divide unit: ALU operation codes, alu_op type codes, R-type
//   function codes, result select codes and the MDU state encoding.
package alu_mdu_controller_pkg;

    // ALU operation codes driven to the datapath ALU.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Instruction class from the main controller.
    typedef enum logic [1:0] {
        OP_MTYPE = 2'b00,
        OP_BTYPE = 2'b01,
        OP_RTYPE = 2'b10,
        OP_JTYPE = 2'b11
    } alu_op_e;

    // R-type function codes.
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Datapath result mux select.
    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_HI  = 2'b01,
        SEL_LO  = 2'b10
    } result_sel_e;

    // MDU sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIN  = 2'b10
    } mdu_state_e;

    // MULT/MULTU/DIV/DIVU share the prefix 0110xx.
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    // Any function that touches the MDU or HI/LO.
    function automatic logic is_mdu(input logic [5:0] f);
        return is_muldiv(f) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

endpackage

// File: rtl/alu_mdu_controller_mdu_iter.sv
// mdu_iter
//   Iterative radix-2 multiply/divide unit with HI/LO result registers.
//   Operands are captured as unsigned magnitudes plus sign flags; WIDTH
//   shift-add (multiply) or restoring shift-subtract (divide) steps follow,
//   then one FIN cycle applies the sign fixup and writes HI/LO.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             accept a new operation (only honoured in IDLE)
//   op_div            1 = divide, 0 = multiply
//   op_signed         1 = signed operands
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   busy              registered, high while not IDLE
//   done              registered one-cycle pulse during FIN
//   hi, lo            result registers
module mdu_iter
    import alu_mdu_controller_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    // acc_q: product high half / partial remainder.
    // q_q:   multiplier (shifted out) / dividend -> quotient (shifted in).
    // m_q:   multiplicand / divisor magnitude.
    logic [WIDTH-1:0] acc_q, q_q, m_q;
    logic             div_q, neg_lo_q, neg_hi_q;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign sa    = op_signed & src_a[WIDTH-1];
    assign sb    = op_signed & src_b[WIDTH-1];
    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign mag_a = sa ? -src_a : src_a;
    assign mag_b = sb ? -src_b : src_b;

    assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {acc_q, q_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_ge    = div_shift >= {1'b0, m_q};

    assign prod     = {acc_q, q_q};
    assign prod_fix = neg_lo_q ? -prod : prod;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (start)              state_d = MDU_RUN;
            MDU_RUN:  if (cnt_q == CNT_W'(1)) state_d = MDU_FIN;
            MDU_FIN:                          state_d = MDU_IDLE;
            default:                          state_d = MDU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the shift registers are plain flops, not memories, so they are
    // reset too; a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != MDU_IDLE);
            done    <= (state_d == MDU_FIN);
            case (state_q)
                MDU_IDLE: if (start) begin
                    cnt_q    <= CNT_W'(WIDTH);
                    acc_q    <= '0;
                    q_q      <= mag_a;
                    m_q      <= mag_b;
                    div_q    <= op_div;
                    // Divide by zero keeps an all-ones quotient unnegated.
                    neg_lo_q <= (sa ^ sb) & ~(op_div & (src_b == '0));
                    neg_hi_q <= sa;
                end
                MDU_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (div_q) begin
                        acc_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        q_q   <= {q_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_sum[WIDTH:1];
                        q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
                    end
                end
                MDU_FIN: begin
                    if (div_q) begin
                        lo <= neg_lo_q ? -q_q : q_q;
                        hi <= neg_hi_q ? -acc_q : acc_q;
                    end else begin
                        lo <= prod_fix[WIDTH-1:0];
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu_controller.sv
// alu_mdu_controller
//   ALU control decoder plus iterative multiply/divide unit with HI/LO.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   valid           instruction present this cycle
//   alu_op, func    instruction class and R-type function field
//   src_a, src_b    rs/rt operands
//   alu_operation   ALU op code (combinational, independent of valid)
//   result_sel      00 ALU, 01 HI, 10 LO (combinational)
//   stall           hold the pipeline: MDU instruction while MDU busy
//   busy, done      MDU iterating / one-cycle completion pulse
//   hi, lo          HI/LO registers
module alu_mdu_controller
    import alu_mdu_controller_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       alu_operation,
    output logic [1:0]       result_sel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic is_r, start;

    assign is_r = (alu_op == OP_RTYPE);

    always_comb begin
        alu_operation = ALU_OFF;
        case (alu_op)
            OP_MTYPE: alu_operation = ALU_ADD;
            OP_BTYPE: alu_operation = ALU_SUB;
            OP_RTYPE: begin
                case (func)
                    F_ADD:   alu_operation = ALU_ADD;
                    F_SUB:   alu_operation = ALU_SUB;
                    F_AND:   alu_operation = ALU_AND;
                    F_OR:    alu_operation = ALU_OR;
                    F_SLT:   alu_operation = ALU_SLT;
                    default: alu_operation = ALU_OFF;
                endcase
            end
            default:  alu_operation = ALU_OFF;
        endcase
    end

    always_comb begin
        result_sel = SEL_ALU;
        if (is_r && func == F_MFHI) result_sel = SEL_HI;
        if (is_r && func == F_MFLO) result_sel = SEL_LO;
    end

    // busy covers RUN and FIN, so a request in FIN is held until IDLE.
    assign stall = valid & is_r & is_mdu(func) & busy;
    assign start = valid & is_r & is_muldiv(func) & ~stall;

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_div    (func[1]),
        .op_signed (~func[0]),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_mdu_controller.sv
module tb_alu_mdu_controller;
    import alu_mdu_controller_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [1:0]   alu_op;
    logic [5:0]   func;
    logic [W-1:0] src_a, src_b;
    logic [2:0]   alu_operation;
    logic [1:0]   result_sel;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mdu_controller #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid         (valid),
        .alu_op        (alu_op),
        .func          (func),
        .src_a         (src_a),
        .src_b         (src_b),
        .alu_operation (alu_operation),
        .result_sel    (result_sel),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .hi            (hi),
        .lo            (lo)
    );

    // Issue one MULT/DIV and sample once per cycle on the falling edge until
    // busy drops (bounded); returns busy-cycle and done-pulse counts.
    task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int busy_cycles, output int done_cnt);
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; func = f; src_a = a; src_b = b;
        @(posedge clk); #1;
        valid = 1'b0; func = F_ADD;
        busy_cycles = 0; done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!busy) break;
            busy_cycles++;
        end
    endtask

    task automatic test_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int bc, dc;
        run_mdu(f, a, b, bc, dc);
        checks++;
        if (bc !== 33) begin failures++; $display("FAIL %s busy_cycles: got %0d expected 33", name, bc); end
        checks++;
        if (dc !== 1) begin failures++; $display("FAIL %s done_pulses: got %0d expected 1", name, dc); end
        checks++;
        if (hi !== exp_hi) begin failures++; $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi); end
        checks++;
        if (lo !== exp_lo) begin failures++; $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; func = 6'd0; src_a = '0; src_b = '0;
        #12;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b expected 0", done); end
        checks++;
        if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset hilo: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_decode();
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; func = 6'b101010; #1;
        checks++;
        if (alu_operation !== 3'b111) begin failures++; $display("FAIL decode slt: got %b expected 111", alu_operation); end
        checks++;
        if (result_sel !== 2'b00) begin failures++; $display("FAIL decode slt sel: got %b expected 00", result_sel); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL decode slt stall: got %b expected 0", stall); end
        func = 6'b100010; #1;
        checks++;
        if (alu_operation !== 3'b110) begin failures++; $display("FAIL decode sub: got %b expected 110", alu_operation); end
        func = 6'b100101; #1;
        checks++;
        if (alu_operation !== 3'b001) begin failures++; $display("FAIL decode or: got %b expected 001", alu_operation); end
        func = 6'b111111; #1;
        checks++;
        if (alu_operation !== ALU_OFF) begin failures++; $display("FAIL decode badfunc: got %b expected %b", alu_operation, ALU_OFF); end
        valid = 1'b0; alu_op = 2'b00; #1;
        checks++;
        if (alu_operation !== 3'b010) begin failures++; $display("FAIL decode mtype: got %b expected 010", alu_operation); end
        alu_op = 2'b01; #1;
        checks++;
        if (alu_operation !== 3'b110) begin failures++; $display("FAIL decode btype: got %b expected 110", alu_operation); end
        alu_op = 2'b11; #1;
        checks++;
        if (alu_operation !== ALU_OFF) begin failures++; $display("FAIL decode jtype: got %b expected %b", alu_operation, ALU_OFF); end
        alu_op = 2'b10; func = 6'b010000; #1;
        checks++;
        if (result_sel !== 2'b01) begin failures++; $display("FAIL decode mfhi sel: got %b expected 01", result_sel); end
    endtask

    task automatic test_hazard();
        int stalls;
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; func = F_MULT; src_a = 32'd5; src_b = 32'd9;
        @(posedge clk); #1;
        func = F_ADD;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hazard add stall/busy: got %b/%b expected 0/1", stall, busy); end
        checks++;
        if (alu_operation !== 3'b010) begin failures++; $display("FAIL hazard add op: got %b expected 010", alu_operation); end
        func = F_MFLO;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
        end
        checks++;
        if (stalls !== 32) begin failures++; $display("FAIL hazard mflo stall_cycles: got %0d expected 32", stalls); end
        checks++;
        if (result_sel !== 2'b10 || lo !== 32'd45) begin failures++; $display("FAIL hazard mflo sel/lo: got %b/%h expected 10/0000002d", result_sel, lo); end
        func = F_MFHI; #1;
        checks++;
        if (result_sel !== 2'b01 || hi !== 32'd0) begin failures++; $display("FAIL hazard mfhi sel/hi: got %b/%h expected 01/00000000", result_sel, hi); end
        valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; func = F_MULTU; src_a = 32'd1234; src_b = 32'd5678;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b expected 0", busy); end
        checks++;
        if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL midreset hilo: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk); rst_n = 1'b1;
        test_op("mult_after_reset", F_MULT, 32'd6, 32'd7, 32'h0000_0000, 32'd42);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        test_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        test_op("mult_minneg", F_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
        test_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_op("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        test_op("divu_zero", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        test_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        test_hazard();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
